muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide engine for MULT, MULTU, DIV and DIVU instructions.
- Sits directly upstream of the hi/lo register and produces its 64-bit write data and write enable.
- Takes one operation at a time, runs a fixed-latency radix-2 iteration, and stalls the pipeline through `busy` while it works.

Parameters:
- WIDTH, 32, operand width; the result is 2*WIDTH bits ({hi, lo}).
- ITER, WIDTH, number of iteration cycles; fixed equal to WIDTH and not overridden independently.

Ports:
- clk_cpu  input  1  CPU clock, rising edge.
- reset  input  1  asynchronous, active-high.
- start  input  1  launches an operation; sampled only in IDLE.
- op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- rs  input  WIDTH  multiplicand / dividend.
- rt  input  WIDTH  multiplier / divisor.
- busy  output  1  high from the cycle after start is accepted until the write cycle ends.
- hilo_wr_en  output  1  one-cycle write pulse to the hi/lo register.
- hilo_wr_data  output  2*WIDTH  {hi, lo}; valid while hilo_wr_en is high.

Behaviour:
- Reset: reset, asynchronous, active-high; clock clk_cpu. All state clears, FSM goes to IDLE, and busy=0, hilo_wr_en=0, hilo_wr_data=0.
- FSM states: IDLE -> CALC -> DONE -> IDLE.
- IDLE:
  - start=1 at edge E0 latches op, |rs|, |rt| (absolute values only for signed ops), the result sign flags and the zero-divisor flag.
  - Iteration counter loads 0; FSM moves to CALC.
- CALC: one iteration per edge, WIDTH iterations in total (E1..E32). At E32 the FSM moves to DONE.
  - Multiply: shift-add into a 2*WIDTH accumulator, LSB of the multiplier first.
  - Divide: restoring division. Remainder shifts left, the next dividend bit shifts in, the divisor is subtracted when the result is non-negative, and the quotient bit is set accordingly.
- DONE (one cycle, after E33):
  - hilo_wr_en=1 and hilo_wr_data holds the sign-corrected result. The FSM returns to IDLE at the next edge.
  - Total latency: start sampled at E0, hi/lo captures at E34.
- Result mapping:
  - Multiply: {hi, lo} = full 64-bit product. For signed ops the product is negated when the operand signs differ.
  - Divide: hi = remainder, lo = quotient. The signed quotient is negated when the signs differ; the signed remainder takes the sign of the dividend.
- Divide by zero: lo = all ones, hi = rs (unmodified). Latency is unchanged unless the optional feature below is enabled.
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): lo = 0x80000000, hi = 0.
- Start while busy: ignored; no queueing. start in the DONE cycle is also ignored.
- busy=0 in IDLE, busy=1 in CALC and DONE.
- hilo_wr_en is never asserted outside DONE.
- Reset mid-operation: the operation is abandoned, no write pulse is issued, and the FSM is in IDLE on the first cycle after reset deasserts.
- Operand inputs are don't-care after E0; the internal copies are used exclusively.

Optional Feature:
- Macro: MULDIV_FAST_ZERO_EN.
- Defined:
  - Divide with rt=0, or multiply with rs=0 or rt=0, skips CALC and goes IDLE -> DONE directly.
  - hi/lo captures at E2. Results are identical to the non-fast path.
- Undefined: every operation takes the full 34-cycle latency.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> single hilo_wr_en pulse with data 0xFFFFFFFE_00000001; busy high for exactly 33 cycles.
- MULT rs=0xFFFFFFFD (-3), rt=7 -> data 0xFFFFFFFF_FFFFFFEB (-21).
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> hi=0xFFFFFFFF (-1), lo=0xFFFFFFFD (-3); DIVU rs=100, rt=7 -> hi=2, lo=14.
- DIV rs=0x80000000, rt=0xFFFFFFFF -> hi=0, lo=0x80000000; DIVU rs=5, rt=0 -> hi=5, lo=0xFFFFFFFF. With MULDIV_FAST_ZERO_EN defined the rt=0 case writes at E2.
- Second start pulsed at E10 with different operands -> ignored; exactly one write pulse carrying the first result.
- Reset asserted at E20 of a MULTU -> busy=0 and hilo_wr_en=0 immediately; no write pulse follows; a new MULTU 3*4 after reset yields data 0x00000000_0000000C.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide engine feeding the hi/lo register.
// Handles MULT, MULTU, DIV and DIVU one at a time. Start is taken at E0, the
// fixed 32 iteration cycles run E1..E32, DONE follows, and the registered write
// pulse presents {hi, lo} so the hi/lo register captures it at E34.
//
// Optional build macro MULDIV_FAST_ZERO_EN: a divide by zero, or a multiply with
// a zero operand, skips CALC and writes at E2. The results do not change.
//
// Ports:
//   clk_cpu      in   CPU clock, rising edge
//   reset        in   asynchronous, active-high
//   start        in   launch request, accepted only while idle
//   op           in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs           in   multiplicand / dividend
//   rt           in   multiplier / divisor
//   busy         out  pipeline stall while an operation is in flight
//   hilo_wr_en   out  one-cycle hi/lo write pulse
//   hilo_wr_data out  {hi, lo} write data
module muldiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic                 clk_cpu,
   input  logic                 reset,
   input  logic                 start,
   input  logic [1:0]           op,
   input  logic [WIDTH-1:0]     rs,
   input  logic [WIDTH-1:0]     rt,
   output logic                 busy,
   output logic                 hilo_wr_en,
   output logic [2*WIDTH-1:0]   hilo_wr_data
);

   localparam int unsigned ITER   = WIDTH;
   localparam int unsigned CNT_W  = (ITER > 1) ? $clog2(ITER) : 1;
   localparam int unsigned RES_W  = 2 * WIDTH;
   localparam int unsigned SUM_W  = WIDTH + 1;
   localparam int unsigned DIFF_W = WIDTH + 2;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               is_div;
   logic               skip;       // zero operand: accumulator already holds the answer
   logic               neg_res;    // negate product / quotient
   logic               neg_rem;    // negate remainder (dividend sign)
   logic [RES_W-1:0]   acc;        // {hi, lo}: product, or {remainder, dividend/quotient}
   logic [WIDTH-1:0]   opnd;       // multiplicand or divisor magnitude

   // Operand magnitudes and sign flags for the launch cycle
   logic               rs_neg, rt_neg, zero_op;
   logic [WIDTH-1:0]   rs_abs, rt_abs;

   always_comb begin
      rs_neg  = ~op[0] & rs[WIDTH-1];
      rt_neg  = ~op[0] & rt[WIDTH-1];
      rs_abs  = rs_neg ? (~rs + WIDTH'(1)) : rs;
      rt_abs  = rt_neg ? (~rt + WIDTH'(1)) : rt;
      zero_op = op[1] ? (rt == '0) : ((rs == '0) || (rt == '0));
   end

   // One radix-2 iteration: shift-add multiply or restoring divide
   logic [SUM_W-1:0]   mul_sum;
   logic [SUM_W-1:0]   div_shift;
   logic [DIFF_W-1:0]  div_diff;
   logic [RES_W-1:0]   acc_step;

   always_comb begin
      mul_sum   = {1'b0, acc[RES_W-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : SUM_W'(0));
      div_shift = {acc[RES_W-1:WIDTH], acc[WIDTH-1]};
      div_diff  = {1'b0, div_shift} - {2'b00, opnd};
      if (is_div) begin
         // borrow out means the trial subtraction went negative: restore
         if (div_diff[DIFF_W-1])
            acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
         else
            acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
         acc_step = {mul_sum, acc[WIDTH-1:1]};
      end
   end

   // Sign-corrected result presented during DONE
   logic [WIDTH-1:0]   acc_hi, acc_lo, res_hi, res_lo;
   logic [RES_W-1:0]   result;

   always_comb begin
      acc_hi = acc[RES_W-1:WIDTH];
      acc_lo = acc[WIDTH-1:0];
      res_hi = neg_rem ? (~acc_hi + WIDTH'(1)) : acc_hi;
      // divide by zero yields all-ones quotient regardless of signs
      res_lo = skip ? '1 : (neg_res ? (~acc_lo + WIDTH'(1)) : acc_lo);
      if (is_div)
         result = {res_hi, res_lo};
      else
         result = neg_res ? (~acc + RES_W'(1)) : acc;
   end

   // Control FSM, datapath registers and registered outputs
   always_ff @(posedge clk_cpu or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         is_div       <= 1'b0;
         skip         <= 1'b0;
         neg_res      <= 1'b0;
         neg_rem      <= 1'b0;
         acc          <= '0;
         opnd         <= '0;
         busy         <= 1'b0;
         hilo_wr_en   <= 1'b0;
         hilo_wr_data <= '0;
      end else begin
         // outputs lag the state by one edge so the write lands at E34
         busy       <= (state != IDLE);
         hilo_wr_en <= (state == DONE);
         if (state == DONE)
            hilo_wr_data <= result;

         case (state)
            IDLE: begin
               // busy still high here means the previous write cycle is in progress
               if (start && !busy) begin
                  is_div  <= op[1];
                  skip    <= zero_op;
                  neg_res <= rs_neg ^ rt_neg;
                  neg_rem <= op[1] & rs_neg;
                  cnt     <= '0;
                  if (op[1]) begin
                     opnd <= rt_abs;
                     acc  <= zero_op ? {rs_abs, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, rs_abs};
                  end else begin
                     opnd <= rs_abs;
                     acc  <= zero_op ? RES_W'(0) : {{WIDTH{1'b0}}, rt_abs};
                  end
`ifdef MULDIV_FAST_ZERO_EN
                  state <= zero_op ? DONE : CALC;
`else
                  state <= CALC;
`endif
               end
            end
            CALC: begin
               if (!skip)
                  acc <= acc_step;
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(ITER - 1))
                  state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with hand-computed results.
module tb_muldiv_unit;

   logic        clk_cpu;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs;
   logic [31:0] rt;
   logic        busy;
   logic        hilo_wr_en;
   logic [63:0] hilo_wr_data;

   int checks = 0;
   int errors = 0;

`ifdef MULDIV_FAST_ZERO_EN
   localparam int ZERO_LAT = 1;
`else
   localparam int ZERO_LAT = 33;
`endif

   muldiv_unit #(.WIDTH(32)) dut (
      .clk_cpu      (clk_cpu),
      .reset        (reset),
      .start        (start),
      .op           (op),
      .rs           (rs),
      .rt           (rt),
      .busy         (busy),
      .hilo_wr_en   (hilo_wr_en),
      .hilo_wr_data (hilo_wr_data)
   );

   initial clk_cpu = 1'b0;
   always #5 clk_cpu = ~clk_cpu;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%016h exp=0x%016h", tag, got, exp);
      end
   endtask

   // Launch one operation at E0 and watch E1..E60. lat is the edge after which
   // hilo_wr_en is first seen high (write captured one edge later); busy is
   // expected high on exactly lat samples.
   task automatic run_op(input string tag, input logic [1:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int lat, input bit inject);
      int          busy_cnt;
      int          pulses;
      int          wr_edge;
      logic [63:0] data;
      busy_cnt = 0; pulses = 0; wr_edge = -1; data = '0;
      @(negedge clk_cpu);
      start = 1'b1; op = o; rs = a; rt = b;
      @(posedge clk_cpu);
      #1;
      start = 1'b0; rs = $urandom; rt = $urandom; op = 2'($urandom);
      for (int e = 1; e <= 60; e++) begin
         @(posedge clk_cpu);
         #1;
         if (busy) busy_cnt++;
         if (hilo_wr_en) begin
            pulses++;
            if (wr_edge < 0) begin
               wr_edge = e;
               data    = hilo_wr_data;
            end
         end
         if (inject && e == 9) begin
            start = 1'b1; op = 2'b01; rs = 32'd9; rt = 32'd9;
         end
         if (inject && e == 10) start = 1'b0;
      end
      chk({tag, "_data"},  data, exp);
      chk({tag, "_pulses"}, 64'(pulses), 64'd1);
      chk({tag, "_lat"},    64'(wr_edge), 64'(lat));
      chk({tag, "_busy"},   64'(busy_cnt), 64'(lat));
   endtask

   initial begin
      int pulses;
      reset = 1'b1; start = 1'b0; op = 2'b00; rs = '0; rt = '0;
      repeat (3) @(posedge clk_cpu);
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_wr",   64'(hilo_wr_en), 64'd0);
      chk("rst_data", hilo_wr_data, 64'd0);
      @(negedge clk_cpu);
      reset = 1'b0;

      run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33, 1'b0);
      run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB, 33, 1'b0);
      run_op("mult_min",  2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 33, 1'b0);
      run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, 33, 1'b0);
      run_op("divu",      2'b11, 32'd100,       32'd7,         64'h0000_0002_0000_000E, 33, 1'b0);
      run_op("divu_one",  2'b11, 32'hFFFF_FFFF, 32'd1,         64'h0000_0000_FFFF_FFFF, 33, 1'b0);
      run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 33, 1'b0);
      run_op("divu_z",    2'b11, 32'd5,         32'd0,         64'h0000_0005_FFFF_FFFF, ZERO_LAT, 1'b0);
      run_op("div_z_neg", 2'b10, 32'hFFFF_FFF9, 32'd0,         64'hFFFF_FFF9_FFFF_FFFF, ZERO_LAT, 1'b0);
      run_op("mult_z",    2'b00, 32'd0,         32'hFFFF_FFFB, 64'd0,                   ZERO_LAT, 1'b0);
      run_op("ign_start", 2'b01, 32'd6,         32'd7,         64'd42,                  33, 1'b1);

      // Reset in the middle of a MULTU abandons it without a write
      @(negedge clk_cpu);
      start = 1'b1; op = 2'b01; rs = 32'h1234_5678; rt = 32'h9ABC_DEF0;
      @(posedge clk_cpu);
      #1;
      start = 1'b0;
      repeat (20) @(posedge clk_cpu);
      #1;
      reset = 1'b1;
      #1;
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_wr",   64'(hilo_wr_en), 64'd0);
      @(negedge clk_cpu);
      @(negedge clk_cpu);
      reset = 1'b0;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk_cpu);
         #1;
         if (hilo_wr_en || busy) pulses++;
      end
      chk("post_rst_quiet", 64'(pulses), 64'd0);
      run_op("after_rst", 2'b01, 32'd3, 32'd4, 64'h0000_0000_0000_000C, 33, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
